// File: rtl/simmem_burst_delay_estimator.sv
// Per-burst latency model: walks an AXI burst beat by beat against one open row,
// accumulates the modelled cost, then releases the iid to the response banks.
module simmem_burst_delay_estimator #(
    parameter int AddrW             = 19,
    parameter int RowBufLenW        = 10,
    parameter int RowHitCost        = 4,
    parameter int PrechargeCost     = 2,
    parameter int ActivationCost    = 1,
    parameter int IidW              = 2,
    parameter int MaxBurstLenFieldW = 2,
    parameter int MaxBurstSizeField = 2,
    parameter int CntW              = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_is_write_i,
    input  logic [IidW-1:0]  req_iid_i,
    input  logic [AddrW-1:0] req_addr_i,
    input  logic [7:0]       req_burst_len_i,
    input  logic [2:0]       req_burst_size_i,
    output logic             rel_valid_o,
    input  logic             rel_ready_i,
    output logic             rel_is_write_o,
    output logic [IidW-1:0]  rel_iid_o,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising clk_i edge where valid and ready
    // are both high; valid never depends on ready, and the release payload is
    // held stable while rel_valid_o is high.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

    localparam int NW   = MaxBurstLenFieldW + 1;
    localparam int RowW = AddrW - RowBufLenW;

    localparam logic [CntW-1:0] COST_HIT  = CntW'(RowHitCost);
    localparam logic [CntW-1:0] COST_OPEN = CntW'(ActivationCost + RowHitCost);
    localparam logic [CntW-1:0] COST_MISS = CntW'(PrechargeCost + ActivationCost + RowHitCost);
    localparam logic [2:0]      MAX_SIZE  = 3'(MaxBurstSizeField);

    logic [1:0]       state;
    logic             is_write_q;
    logic [IidW-1:0]  iid_q;
    logic [AddrW-1:0] beat_addr_q;
    logic [AddrW-1:0] stride_q;
    logic [NW-1:0]    n_q;
    logic [NW-1:0]    beats_left_q;
    logic [CntW-1:0]  acc_q;
    logic [RowW-1:0]  open_row_q;
    logic             open_row_valid_q;

    logic [2:0]       size_sel;
    logic [AddrW-1:0] stride_in;
    logic [NW-1:0]    n_in;
    logic [RowW-1:0]  beat_row;
    logic [CntW-1:0]  beat_cost;
    logic [CntW-1:0]  acc_next;

    always_comb begin
        size_sel  = (req_burst_size_i > MAX_SIZE) ? MAX_SIZE : req_burst_size_i;
        stride_in = AddrW'(1) << size_sel;
        n_in      = NW'(req_burst_len_i[MaxBurstLenFieldW-1:0]) + NW'(1);
        beat_row  = beat_addr_q[AddrW-1:RowBufLenW];
        if (!open_row_valid_q) begin
            beat_cost = COST_OPEN;
        end else if (beat_row == open_row_q) begin
            beat_cost = COST_HIT;
        end else begin
            beat_cost = COST_MISS;
        end
        acc_next = acc_q + beat_cost;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            is_write_q       <= 1'b0;
            iid_q            <= '0;
            beat_addr_q      <= '0;
            stride_q         <= '0;
            n_q              <= '0;
            beats_left_q     <= '0;
            acc_q            <= '0;
            open_row_q       <= '0;
            open_row_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        is_write_q   <= req_is_write_i;
                        iid_q        <= req_iid_i;
                        beat_addr_q  <= req_addr_i;
                        stride_q     <= stride_in;
                        n_q          <= n_in;
                        beats_left_q <= n_in;
                        acc_q        <= '0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    beat_addr_q      <= beat_addr_q + stride_q;
                    beats_left_q     <= beats_left_q - NW'(1);
                    open_row_q       <= beat_row;
                    open_row_valid_q <= 1'b1;
                    // The N CALC cycles and the REL entry cycle are already part
                    // of the latency, so only the remainder is counted in WAIT.
                    if (beats_left_q == NW'(1)) begin
                        acc_q <= acc_next - CntW'(n_q) - CntW'(1);
                        state <= WAIT;
                    end else begin
                        acc_q <= acc_next;
                    end
                end
                WAIT: begin
                    acc_q <= acc_q - CntW'(1);
                    if (acc_q == CntW'(1)) begin
                        state <= REL;
                    end
                end
                REL: begin
                    if (rel_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state == IDLE) && !rst_i;
    assign rel_valid_o    = (state == REL);
    assign rel_is_write_o = is_write_q;
    assign rel_iid_o      = iid_q;
    assign dbg_state_o    = state;

endmodule
